// File: rtl/aes_ctr_pkg.sv
// Shared types for the AES-CTR stream front-end: block type, plaintext beat payload, FSM states.
package aes_ctr_pkg;

    localparam int unsigned BLOCK_W = 128;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef struct packed {
        logic   last;
        block_t data;
    } pt_beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; power-of-2 depth, reset flushes pointers only.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/axis_ctr_xor.sv
// AES-256-CTR front-end: issues one counter block per plaintext beat and XORs the
// in-order keystream back onto the buffered plaintext; in-flight blocks are bounded by FIFO_DEPTH.
module axis_ctr_xor
    import aes_ctr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = BLOCK_W,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CTR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] iv,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] ctr_tdata,
    output logic                  ctr_tvalid,
    input  logic                  ctr_tready,
    input  logic [DATA_WIDTH-1:0] ks_tdata,
    input  logic                  ks_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned IFW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PTW = $bits(pt_beat_t);

    ctr_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] ctr_q, ctr_d;
    logic [IFW-1:0]        in_flight_q, in_flight_d;
    logic [IFW-1:0]        ks_pending_q, ks_pending_d;
    logic                  err_q, err_d;
    logic                  ks_vld_q, ks_vld_d;
    block_t                ks_data_q, ks_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic     room;
    logic     in_hs;
    logic     out_hs;
    logic     out_load;
    logic     ks_accept;
    logic     pt_full, pt_empty;
    logic     ks_full, ks_empty;
    pt_beat_t pt_in;
    pt_beat_t pt_head;
    block_t   ks_head;

    // Counter and plaintext handshakes are tied together so they always coincide.
    assign room          = (in_flight_q < IFW'(FIFO_DEPTH));
    assign ctr_tvalid    = (state_q == RUN) && s_axis_tvalid && room;
    assign s_axis_tready = (state_q == RUN) && ctr_tready && room;
    assign in_hs         = ctr_tvalid && ctr_tready;
    assign ctr_tdata     = ctr_q;

    assign ks_accept = ks_tvalid && (ks_pending_q != '0);
    assign out_hs    = out_valid_q && m_axis_tready;
    assign out_load  = !pt_empty && !ks_empty && (!out_valid_q || m_axis_tready);
    assign pt_in     = '{last: s_axis_tlast, data: BLOCK_W'(s_axis_tdata)};

    sync_fifo #(
        .WIDTH (PTW),
        .DEPTH (FIFO_DEPTH)
    ) u_pt_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_hs && !pt_full),
        .wdata_i (pt_in),
        .pop_i   (out_load),
        .rdata_o (pt_head),
        .full_o  (pt_full),
        .empty_o (pt_empty)
    );

    sync_fifo #(
        .WIDTH (BLOCK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ks_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ks_vld_q && !ks_full),
        .wdata_i (ks_data_q),
        .pop_i   (out_load),
        .rdata_o (ks_head),
        .full_o  (ks_full),
        .empty_o (ks_empty)
    );

    always_comb begin
        state_d      = state_q;
        ctr_d        = ctr_q;
        in_flight_d  = in_flight_q;
        ks_pending_d = ks_pending_q;
        err_d        = err_q;
        ks_vld_d     = ks_accept;
        ks_data_d    = BLOCK_W'(ks_tdata);
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;

        // in_flight spans input handshake through output acceptance.
        case ({in_hs, out_hs})
            2'b10:   in_flight_d = in_flight_q + IFW'(1);
            2'b01:   in_flight_d = in_flight_q - IFW'(1);
            default: in_flight_d = in_flight_q;
        endcase

        case ({in_hs, ks_accept})
            2'b10:   ks_pending_d = ks_pending_q + IFW'(1);
            2'b01:   ks_pending_d = ks_pending_q - IFW'(1);
            default: ks_pending_d = ks_pending_q;
        endcase

        if (ks_tvalid && (ks_pending_q == '0)) begin
            err_d = 1'b1;
        end

        // Only the low CTR_WIDTH bits roll; the nonce part stays put on wrap.
        if (in_hs) begin
            ctr_d[CTR_WIDTH-1:0] = ctr_q[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
        end

        if (out_load) begin
            out_valid_d = 1'b1;
            out_last_d  = pt_head.last;
            out_data_d  = DATA_WIDTH'(pt_head.data ^ ks_head);
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    ctr_d   = iv;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (in_hs && s_axis_tlast) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (in_flight_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ctr_q        <= '0;
            in_flight_q  <= '0;
            ks_pending_q <= '0;
            err_q        <= 1'b0;
            ks_vld_q     <= 1'b0;
            ks_data_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            in_flight_q  <= in_flight_d;
            ks_pending_q <= ks_pending_d;
            err_q        <= err_d;
            ks_vld_q     <= ks_vld_d;
            ks_data_q    <= ks_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tdata  = out_data_q;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;

endmodule
